// File: rtl/riscv_crypto_sm4_block_ctrl.sv
// riscv_crypto_sm4_block_ctrl
//   Sequences full SM4 block operations (optional key expansion followed by
//   32 encrypt/decrypt rounds) over a single byte-serial SM4 round unit,
//   riscv_crypto_fu_ssm4, which is also defined in this file.
//
// riscv_crypto_fu_ssm4 ports:
//   rs1        accumulator word XORed into the result
//   rs2        round input word; byte bs goes through the S-box
//   bs         byte select, 0 = bits [7:0]
//   op_ssm4_ks key-schedule linear transform L'
//   op_ssm4_ed encrypt/decrypt linear transform L
//   result     rs1 ^ rotl(L(Sbox(rs2.byte[bs])), 8*bs)
//
// riscv_crypto_sm4_block_ctrl ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_new_key, req_dec         force key expansion, decrypt
//   req_key, req_data            master key, input block (word 0 in MSBs)
//   rsp_valid/rsp_ready/rsp_data response handshake and result
//   key_valid                    round-key store holds a full schedule
//   busy                         controller not idle
//
// States:
//   IDLE | waiting for a request, req_ready high
//   KS   | key expansion, 32 rounds x 4 byte steps
//   ED   | data pass, 32 rounds x 4 byte steps
//   DONE | result held on rsp_data until rsp_ready

module riscv_crypto_fu_ssm4 (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [1:0]  bs,
    input  logic        op_ssm4_ks,
    input  logic        op_ssm4_ed,
    output logic [31:0] result
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [7:0]  sb_in;
    logic [31:0] x;
    logic [31:0] lin;
    logic [31:0] rot;

    always_comb begin
        case (bs)
            2'd0:    sb_in = rs2[7:0];
            2'd1:    sb_in = rs2[15:8];
            2'd2:    sb_in = rs2[23:16];
            default: sb_in = rs2[31:24];
        endcase

        x = {24'd0, SBOX[sb_in]};

        // The byte sits at the LSBs, so every rotation in L / L' fits without
        // wrap and reduces to a plain shift.
        if (op_ssm4_ks) begin
            lin = x ^ (x << 13) ^ (x << 23);
        end else if (op_ssm4_ed) begin
            lin = x ^ (x << 2) ^ (x << 10) ^ (x << 18) ^ (x << 24);
        end else begin
            lin = 32'd0;
        end

        // L commutes with byte rotation, so move the contribution back to
        // the lane the byte came from.
        case (bs)
            2'd0:    rot = lin;
            2'd1:    rot = {lin[23:0], lin[31:24]};
            2'd2:    rot = {lin[15:0], lin[31:16]};
            default: rot = {lin[7:0],  lin[31:8]};
        endcase

        result = rs1 ^ rot;
    end

endmodule

module riscv_crypto_sm4_block_ctrl #(
    parameter int DEC_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_new_key,
    input  logic         req_dec,
    input  logic [127:0] req_key,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         key_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KS   = 2'd1,
        ED   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    localparam bit DEC_ON = (DEC_EN != 0);

    state_t       state_q, state_d;
    logic [4:0]   round_q, round_d;
    logic [1:0]   bs_q, bs_d;
    logic [31:0]  win_q [4];
    logic [31:0]  win_d [4];
    logic [31:0]  acc_q, acc_d;
    logic [127:0] data_q, data_d;
    logic         dec_q, dec_d;
    logic         key_valid_q, key_valid_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic [31:0]  rk_q [32];

    logic [31:0]  fu_rs1, fu_rs2, fu_result;
    logic         op_ks, op_ed;
    logic [7:0]   ck_base;
    logic [31:0]  ck_word;
    logic [4:0]   rk_idx;

    riscv_crypto_fu_ssm4 u_fu (
        .rs1        (fu_rs1),
        .rs2        (fu_rs2),
        .bs         (bs_q),
        .op_ssm4_ks (op_ks),
        .op_ssm4_ed (op_ed),
        .result     (fu_result)
    );

    // CK_i byte j = (4i+j)*7 mod 256; the 8-bit products wrap naturally.
    assign ck_base = {1'b0, round_q, 2'b00};
    assign ck_word = {ck_base * 8'd7,
                      (ck_base + 8'd1) * 8'd7,
                      (ck_base + 8'd2) * 8'd7,
                      (ck_base + 8'd3) * 8'd7};

    // 31-i for a 5-bit index is its bitwise complement.
    assign rk_idx = dec_q ? ~round_q : round_q;

    assign op_ks  = (state_q == KS);
    assign op_ed  = (state_q == ED);
    assign fu_rs1 = (bs_q == 2'd0) ? win_q[0] : acc_q;
    assign fu_rs2 = win_q[1] ^ win_q[2] ^ win_q[3] ^ (op_ks ? ck_word : rk_q[rk_idx]);

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign key_valid = key_valid_q;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        bs_d        = bs_q;
        win_d       = win_q;
        acc_d       = acc_q;
        data_d      = data_q;
        dec_d       = dec_q;
        key_valid_d = key_valid_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d  = req_data;
                    dec_d   = req_dec & DEC_ON;
                    round_d = 5'd0;
                    bs_d    = 2'd0;
                    if (req_new_key || !key_valid_q) begin
                        // The key is captured directly into the window as K0..K3.
                        state_d     = KS;
                        key_valid_d = 1'b0;
                        for (int w = 0; w < 4; w++) begin
                            win_d[w] = req_key[127-32*w -: 32] ^ FK[w];
                        end
                    end else begin
                        state_d = ED;
                        for (int w = 0; w < 4; w++) begin
                            win_d[w] = req_data[127-32*w -: 32];
                        end
                    end
                end
            end

            KS, ED: begin
                bs_d = bs_q + 2'd1;
                if (bs_q != 2'd3) begin
                    acc_d = fu_result;
                end else begin
                    round_d  = round_q + 5'd1;
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    win_d[2] = win_q[3];
                    win_d[3] = fu_result;
                    if (round_q == 5'd31) begin
                        if (state_q == KS) begin
                            state_d     = ED;
                            key_valid_d = 1'b1;
                            for (int w = 0; w < 4; w++) begin
                                win_d[w] = data_q[127-32*w -: 32];
                            end
                        end else begin
                            state_d    = DONE;
                            rsp_data_d = {fu_result, win_q[3], win_q[2], win_q[1]};
                        end
                    end
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            round_q     <= 5'd0;
            bs_q        <= 2'd0;
            win_q       <= '{default: 32'd0};
            acc_q       <= 32'd0;
            data_q      <= 128'd0;
            dec_q       <= 1'b0;
            key_valid_q <= 1'b0;
            rsp_data_q  <= 128'd0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            bs_q        <= bs_d;
            win_q       <= win_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            dec_q       <= dec_d;
            key_valid_q <= key_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Round-key store needs no reset: key_valid gates its use.
    always_ff @(posedge clk) begin
        if (state_q == KS && bs_q == 2'd3) begin
            rk_q[round_q] <= fu_result;
        end
    end

endmodule

// File: tb/tb_riscv_crypto_sm4_block_ctrl.sv
module tb_riscv_crypto_sm4_block_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_new_key = 1'b0;
    logic         req_dec = 1'b0;
    logic [127:0] req_key = '0;
    logic [127:0] req_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         key_valid;
    logic         busy;

    logic         req_ready2, rsp_valid2, key_valid2, busy2;
    logic [127:0] rsp_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_crypto_sm4_block_ctrl #(.DEC_EN(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_new_key(req_new_key), .req_dec(req_dec), .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .key_valid(key_valid), .busy(busy)
    );

    // Encrypt-only instance fed identically; its control flow matches dut.
    riscv_crypto_sm4_block_ctrl #(.DEC_EN(0)) dut_nodec (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_new_key(req_new_key), .req_dec(req_dec), .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .key_valid(key_valid2), .busy(busy2)
    );

    localparam logic [127:0] VEC_PT = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] VEC_CT = 128'h681EDF34D206965E86B3E94F536E4246;

    localparam logic [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };
    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    // Reference model state: stored schedule and whether it is valid.
    logic [31:0] m_rk [32];
    bit          m_kv = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] w);
        return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
    endfunction

    function automatic void m_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK[i];
        for (int i = 0; i < 32; i++) begin
            ck = 32'd0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            begin
                logic [31:0] b;
                b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
                k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
            end
            m_rk[i] = k[i+4];
        end
    endfunction

    function automatic logic [127:0] m_crypt(input logic [127:0] din, input bit dec);
        logic [31:0] x [36];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) x[i] = din[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? m_rk[31-i] : m_rk[i]));
            x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_kv = 1'b0;
        @(negedge clk);
    endtask

    // One complete transaction, entered and left on a falling edge.
    task automatic do_txn(input logic [127:0] key, input logic [127:0] din, input bit nk,
                          input bit dec, input int hold, input bit keep_valid);
        logic [127:0] exp_main, exp_enc, first;
        int           exp_lat, n, lat;
        bit           stable;

        if (nk || !m_kv) begin
            m_expand(key);
            m_kv    = 1'b1;
            exp_lat = 257;
        end else begin
            exp_lat = 129;
        end
        exp_main = m_crypt(din, dec);
        exp_enc  = m_crypt(din, 1'b0);

        n = 0;
        while (!req_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("wait_req_ready", 128'(req_ready), 128'd1);

        req_valid   = 1'b1;
        req_key     = key;
        req_data    = din;
        req_new_key = nk;
        req_dec     = dec;
        @(negedge clk);
        if (!keep_valid) begin
            req_valid   = 1'b0;
            req_key     = {$urandom, $urandom, $urandom, $urandom};
            req_data    = {$urandom, $urandom, $urandom, $urandom};
            req_new_key = 1'($urandom);
            req_dec     = 1'($urandom);
        end
        chk("busy_after_accept", {126'd0, busy, req_ready}, 128'b10);

        lat = 1;
        while (!rsp_valid && lat < 400) begin
            rsp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        rsp_ready = 1'b0;

        chk("latency", 128'(lat), 128'(exp_lat));
        chk("rsp_data", rsp_data, exp_main);
        chk("rsp_data_nodec", rsp_data2, exp_enc);
        chk("key_valid", 128'(key_valid), 128'd1);

        first  = rsp_data;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== first || req_ready) stable = 1'b0;
        end
        chk("rsp_hold_stable", 128'(stable), 128'd1);
        chk("ready_low_in_done", {126'd0, rsp_valid, req_ready}, 128'b10);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_rsp", {125'd0, rsp_valid, req_ready, busy}, 128'b010);
    endtask

    initial begin
        logic [127:0] k, d;
        bit           nk, dc;
        bit           no_rsp;

        do_reset();
        chk("reset_state", {rsp_data, 1'b0} ^ {127'd0, 1'b0} | 129'(0), 129'd0);
        chk("reset_flags", {123'd0, req_ready, busy, rsp_valid, key_valid, 1'b0}, 128'b10000);

        // First request after reset without new_key still expands.
        do_txn(VEC_PT, VEC_PT, 1'b0, 1'b0, 0, 1'b0);
        chk("ct_known_first", rsp_data == VEC_CT ? 128'd1 : 128'd0, 128'd1);
        chk("rk0",  128'(dut.rk_q[0]),  128'(32'hF12186F9));
        chk("rk31", 128'(dut.rk_q[31]), 128'(32'h9124A012));

        // Decrypt with the stored key.
        do_txn(VEC_PT, VEC_CT, 1'b0, 1'b1, 0, 1'b0);
        chk("pt_known_dec", rsp_data == VEC_PT ? 128'd1 : 128'd0, 128'd1);

        // Explicit new key, encrypt.
        do_txn(VEC_PT, VEC_PT, 1'b1, 1'b0, 2, 1'b0);

        // Consumer stalls 10 cycles while another request waits; it must be
        // accepted only after the response handshake (same request replays).
        do_txn(VEC_PT, VEC_PT, 1'b0, 1'b0, 10, 1'b1);
        do_txn(VEC_PT, VEC_PT, 1'b0, 1'b0, 1, 1'b0);

        // Decrypt request on the encrypt-only instance still encrypts.
        do_txn(VEC_PT, VEC_PT, 1'b0, 1'b1, 0, 1'b0);
        chk("nodec_ct", rsp_data2 == VEC_CT ? 128'd1 : 128'd0, 128'd1);

        // Reset in the middle of key expansion.
        req_valid = 1'b1; req_key = VEC_PT; req_data = VEC_PT; req_new_key = 1'b1; req_dec = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (59) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_flags", {125'd0, key_valid, busy, rsp_valid}, 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        m_kv = 1'b0;
        no_rsp = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid || busy) no_rsp = 1'b0;
        end
        chk("abort_no_rsp", 128'(no_rsp), 128'd1);
        do_txn(VEC_PT, VEC_PT, 1'b0, 1'b0, 0, 1'b0);
        chk("ct_after_abort", rsp_data == VEC_CT ? 128'd1 : 128'd0, 128'd1);

        // Randomized traffic against the model.
        for (int t = 0; t < 20; t++) begin
            if (t == 0 || $urandom_range(2) == 0) k = {$urandom, $urandom, $urandom, $urandom};
            d  = {$urandom, $urandom, $urandom, $urandom};
            nk = ($urandom_range(3) == 0);
            dc = 1'($urandom);
            do_txn(k, d, nk, dc, int'($urandom_range(3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
